vga_sync_decoder: RTL

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and a lock indication from a VGA hs/vs/blank stream.
// Line and frame lengths are measured continuously and compared against the expected active size.
module vga_sync_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        blank,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        de,
  output logic        new_frame,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic        locked,
  output logic        err
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  state_t      state, next_state;
  logic        err_next;
  logic        hs_r, hs_rr, vs_r, vs_rr, blank_r;
  logic        hs_edge, vs_edge;
  logic [10:0] h_cnt, v_cnt, act_cnt, act_lines;
  logic [9:0]  y_cnt;
  logic        meas_bad, meas_ref;

  logic [11:0] len_ext;
  logic [10:0] line_len, frame_lines, frame_vcnt, x_base, act_next;
  logic [9:0]  y_base;
  logic        line_active, line_ok, h_sat, meas_bad_now, lock_viol;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_r    <= ~SYNC_POL;
      hs_rr   <= ~SYNC_POL;
      vs_r    <= ~SYNC_POL;
      vs_rr   <= ~SYNC_POL;
      blank_r <= 1'b0;
    end else begin
      hs_r    <= hs;
      hs_rr   <= hs_r;
      vs_r    <= vs;
      vs_rr   <= vs_r;
      blank_r <= blank;
    end
  end

  assign hs_edge = (hs_r == SYNC_POL) && (hs_rr != SYNC_POL);
  assign vs_edge = (vs_r == SYNC_POL) && (vs_rr != SYNC_POL);

  // h_cnt counts cycles since the last hs edge, so the closing line is one longer.
  assign len_ext     = {1'b0, h_cnt} + 12'd1;
  assign line_len    = len_ext[11] ? CNT_MAX : len_ext[10:0];
  assign line_active = (act_cnt != 11'd0);
  assign line_ok     = !line_active || (act_cnt == H_ACT);
  assign h_sat       = (h_cnt == CNT_MAX);

  // Totals include an hs edge that lands in the same cycle as the vs edge.
  assign frame_lines = (hs_edge && line_active && act_lines != CNT_MAX) ? act_lines + 11'd1 : act_lines;
  assign frame_vcnt  = (hs_edge && v_cnt != CNT_MAX) ? v_cnt + 11'd1 : v_cnt;

  assign x_base   = hs_edge ? 11'd0 : act_cnt;
  assign act_next = (blank_r && x_base != CNT_MAX) ? x_base + 11'd1 : x_base;
  assign y_base   = vs_edge ? 10'd0 :
                    (hs_edge && line_active && y_cnt != 10'h3FF) ? y_cnt + 10'd1 : y_cnt;

  assign meas_bad_now = meas_bad || h_sat ||
                        (hs_edge && (!line_ok || (meas_ref && line_len != h_total)));
  assign lock_viol    = h_sat ||
                        (hs_edge && (line_len != h_total || !line_ok)) ||
                        (vs_edge && (frame_vcnt != v_total || frame_lines != V_ACT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      act_cnt   <= '0;
      act_lines <= '0;
      y_cnt     <= '0;
      h_total   <= '0;
      v_total   <= '0;
      x         <= '0;
      y         <= '0;
      de        <= 1'b0;
      new_frame <= 1'b0;
      meas_bad  <= 1'b0;
      meas_ref  <= 1'b0;
    end else begin
      h_cnt     <= hs_edge ? 11'd0 : (h_sat ? h_cnt : h_cnt + 11'd1);
      v_cnt     <= vs_edge ? 11'd0 : frame_vcnt;
      act_lines <= vs_edge ? 11'd0 : frame_lines;
      act_cnt   <= act_next;
      y_cnt     <= y_base;
      if (hs_edge) h_total <= line_len;
      if (vs_edge) v_total <= frame_vcnt;
      x         <= x_base[10] ? 10'h3FF : x_base[9:0];
      y         <= y_base;
      de        <= blank_r;
      new_frame <= vs_edge;
      // The first line closed in MEASURE only sets the reference length.
      if (state != MEASURE) begin
        meas_bad <= 1'b0;
        meas_ref <= 1'b0;
      end else begin
        meas_bad <= meas_bad_now;
        if (hs_edge) meas_ref <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      err   <= err_next;
    end
  end

  always_comb begin
    next_state = state;
    err_next   = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_edge) next_state = MEASURE;
      end
      MEASURE: begin
        if (vs_edge) begin
          if (!meas_bad_now && frame_lines == V_ACT) begin
            next_state = LOCKED;
          end else begin
            err_next   = 1'b1;
            next_state = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (lock_viol) begin
          err_next   = 1'b1;
          next_state = SEARCH;
        end
      end
      default: next_state = SEARCH;
    endcase
  end

  assign locked = (state == LOCKED);

endmodule
